// File: rtl/deser_rx_pkg.sv
// Shared types for the deser_rx serial-to-parallel receiver.
// State encodings and the bit-counter width helper.
package deser_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        FULL   = 2'd3
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/deser_rx_bit_counter.sv
// Synchronous-reset up-counter tracking bits collected toward a word.
// tc flags that the next accepted bit is the final data bit.
module deser_rx_bit_counter
    import deser_rx_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clear,
    input  logic          load1,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= CW'(1);
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/deser_rx.sv
// Serial-to-parallel receiver, LSB first, valid/ready on both sides.
// Define DESER_PARITY_EN to add a trailing even-parity bit and PERR flag.
module deser_rx
    import deser_rx_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW = cnt_width(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             D,
    input  logic             D_VALID,
    output logic             D_READY,
    output logic [WIDTH-1:0] Q,
    output logic             Q_VALID,
    input  logic             Q_READY,
    output logic [CW-1:0]    BITCNT,
    output logic             PERR
);

    state_t        state;
    logic          xfer;
    logic          consume;
    logic          last;
    logic          cnt_tc;
    logic [CW-1:0] widx;

    assign D_READY = !RST && (state != FULL || Q_READY);
    assign xfer    = D_VALID && D_READY;
    assign consume = (state == FULL) && Q_READY;
    // A bit taken while a word is consumed starts the next word at Q[0].
    assign widx    = consume ? '0 : BITCNT;
    assign last    = consume ? (WIDTH == 1) : cnt_tc;

    deser_rx_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (xfer && (state == IDLE || state == SHIFT)),
        .clear (consume && !xfer),
        .load1 (consume && xfer),
        .cnt   (BITCNT),
        .tc    (cnt_tc)
    );

`ifdef DESER_PARITY_EN
    logic perr_q;
    assign PERR = perr_q;
`else
    assign PERR = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            Q       <= '0;
            Q_VALID <= 1'b0;
`ifdef DESER_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            if (consume) begin
                state   <= IDLE;
                Q_VALID <= 1'b0;
`ifdef DESER_PARITY_EN
                perr_q  <= 1'b0;
`endif
            end
            if (xfer) begin
`ifdef DESER_PARITY_EN
                if (state == PARITY) begin
                    state   <= FULL;
                    Q_VALID <= 1'b1;
                    perr_q  <= ^Q ^ D;
                end else begin
`else
                begin
`endif
                    for (int i = 0; i < WIDTH; i++) begin
                        if (widx == CW'(i)) begin
                            Q[i] <= D;
                        end
                    end
                    if (last) begin
`ifdef DESER_PARITY_EN
                        state   <= PARITY;
`else
                        state   <= FULL;
                        Q_VALID <= 1'b1;
`endif
                    end else begin
                        state <= SHIFT;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_deser_rx.sv
// Directed scoreboard bench for deser_rx at WIDTH=8.
// Honours DESER_PARITY_EN when the design is built with it.
module tb_deser_rx;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    typedef struct packed {
        logic [W-1:0] w;
        logic         p;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          D;
    logic          D_VALID;
    logic          D_READY;
    logic [W-1:0]  Q;
    logic          Q_VALID;
    logic          Q_READY;
    logic [CW-1:0] BITCNT;
    logic          PERR;

    int   checks = 0;
    int   errors = 0;
    int   stalls = 0;
    int   hs     = 0;
    int   hs0;
    exp_t sb[$];

    deser_rx #(.WIDTH(W)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .D       (D),
        .D_VALID (D_VALID),
        .D_READY (D_READY),
        .Q       (Q),
        .Q_VALID (Q_VALID),
        .Q_READY (Q_READY),
        .BITCNT  (BITCNT),
        .PERR    (PERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic [W-1:0] w, input logic p);
        exp_t e;
        e.w = w;
        e.p = p;
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        int n;
        n = 0;
        D       = b;
        D_VALID = 1'b1;
        @(negedge CLK);
        while (!D_READY && n < 100) begin
            stalls++;
            n++;
            @(negedge CLK);
        end
        if (!D_READY) chk("send_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int lo,
                             input int hi);
        for (int i = lo; i <= hi; i++) send_bit(w[i]);
    endtask

    task automatic send_par(input logic [W-1:0] w);
`ifdef DESER_PARITY_EN
        send_bit(^w);
`else
        if (w === 'x) send_bit(1'b0);
`endif
    endtask

    task automatic send_word(input logic [W-1:0] w);
        push_exp(w, 1'b0);
        send_bits(w, 0, W - 1);
        send_par(w);
    endtask

    // Consumer-side scoreboard: every accepted word is popped and compared.
    always @(negedge CLK) begin
        if (!RST && Q_VALID && Q_READY) begin
            hs++;
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_word", 32'(Q), 32'(e.w));
                chk("sb_perr", 32'(PERR), 32'(e.p));
            end
        end
    end

    initial begin
        RST     = 1'b1;
        D       = 1'b1;
        D_VALID = 1'b1;
        Q_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_q", 32'(Q), 32'h0);
        chk("rst_qv", 32'(Q_VALID), 32'h0);
        chk("rst_cnt", 32'(BITCNT), 32'h0);
        chk("rst_dready", 32'(D_READY), 32'h0);
        chk("rst_perr", 32'(PERR), 32'h0);
        RST     = 1'b0;
        D_VALID = 1'b0;
        #1;
        chk("rel_dready", 32'(D_READY), 32'h1);

        send_bits(8'h4D, 0, 2);
        D_VALID = 1'b0;
        chk("gap_cnt0", 32'(BITCNT), 32'd3);
        repeat (3) step();
        chk("gap_cnt3", 32'(BITCNT), 32'd3);
        chk("gap_qv", 32'(Q_VALID), 32'h0);
        send_bits(8'h4D, 3, 7);
`ifdef DESER_PARITY_EN
        chk("par_wait_qv", 32'(Q_VALID), 32'h0);
        chk("par_wait_cnt", 32'(BITCNT), 32'd8);
        send_par(8'h4D);
`endif
        chk("word_qv", 32'(Q_VALID), 32'h1);
        chk("word_q", 32'(Q), 32'h4D);
        chk("word_cnt", 32'(BITCNT), 32'd8);
        chk("word_perr", 32'(PERR), 32'h0);

        D       = 1'b0;
        D_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("hold_dready", 32'(D_READY), 32'h0);
            chk("hold_q", 32'(Q), 32'h4D);
            chk("hold_qv", 32'(Q_VALID), 32'h1);
            @(posedge CLK);
            #1;
        end
        push_exp(8'h4D, 1'b0);
        Q_READY = 1'b1;
        send_word(8'h3C);
        D_VALID = 1'b0;
        step();
        chk("drain_qv", 32'(Q_VALID), 32'h0);
        chk("drain_cnt", 32'(BITCNT), 32'h0);

        stalls = 0;
        send_word(8'hA5);
        push_exp(8'h3C, 1'b0);
        send_bits(8'h3C, 0, 0);
        chk("stream_cnt1", 32'(BITCNT), 32'd1);
        chk("stream_q0", 32'(Q[0]), 32'h0);
        chk("stream_qv0", 32'(Q_VALID), 32'h0);
        send_bits(8'h3C, 1, 7);
        send_par(8'h3C);
        send_word(8'hFF);
        D_VALID = 1'b0;
        step();
        chk("stream_stalls", 32'(stalls), 32'd0);
        chk("stream_qv_end", 32'(Q_VALID), 32'h0);
        chk("stream_sb", 32'(sb.size()), 32'd0);

        hs0 = hs;
        send_bits(8'hA5, 0, 4);
        D_VALID = 1'b0;
        RST     = 1'b1;
        step();
        RST = 1'b0;
        chk("mid_rst_cnt", 32'(BITCNT), 32'h0);
        chk("mid_rst_q", 32'(Q), 32'h0);
        chk("mid_rst_qv", 32'(Q_VALID), 32'h0);
        send_word(8'h3C);
        D_VALID = 1'b0;
        repeat (3) step();
        chk("mid_rst_pulses", 32'(hs - hs0), 32'd1);
        chk("mid_rst_sb", 32'(sb.size()), 32'd0);

`ifdef DESER_PARITY_EN
        Q_READY = 1'b0;
        send_bits(8'h4D, 0, 7);
        chk("p0_qv_pre", 32'(Q_VALID), 32'h0);
        send_bit(1'b0);
        D_VALID = 1'b0;
        chk("p0_qv", 32'(Q_VALID), 32'h1);
        chk("p0_perr", 32'(PERR), 32'h0);
        push_exp(8'h4D, 1'b0);
        Q_READY = 1'b1;
        step();
        Q_READY = 1'b0;
        send_bits(8'h4D, 0, 7);
        chk("p1_qv_pre", 32'(Q_VALID), 32'h0);
        send_bit(1'b1);
        D_VALID = 1'b0;
        chk("p1_qv", 32'(Q_VALID), 32'h1);
        chk("p1_perr", 32'(PERR), 32'h1);
        push_exp(8'h4D, 1'b1);
        Q_READY = 1'b1;
        step();
        chk("p1_perr_clr", 32'(PERR), 32'h0);
        chk("p1_qv_clr", 32'(Q_VALID), 32'h0);
`endif

        chk("final_sb", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
